// File: rtl/grn_scheduler.sv
// grn_scheduler
// Hands GRN initial states to a bank of workers, services their completions
// with a round-robin arbiter, and packs (transient, result) pairs into 512-bit
// lines for the host write path.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start, all outputs low
// LAUNCH | first wave of start pulses (workers 0..L-1) visible
// RUN    | waiting for a done from an active worker, one grant per visit
// ISSUE  | start/retire pulse of the granted worker visible
// WRITE  | packed line offered on the write channel until accepted
// FINISH | everything simulated and written, left only by rst
module grn_scheduler #(
    parameter int BLOCKS_NUMBER = 16,
    parameter int VECTOR_SIZE   = 69,
    parameter int TOTAL_STATES  = 96
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    output logic [BLOCKS_NUMBER-1:0]               start_o,
    output logic [BLOCKS_NUMBER*VECTOR_SIZE-1:0]   conf_o,
    output logic [BLOCKS_NUMBER-1:0]               retire_o,
    input  logic [BLOCKS_NUMBER-1:0]               done_i,
    input  logic [BLOCKS_NUMBER*32-1:0]            transient_i,
    input  logic [BLOCKS_NUMBER*VECTOR_SIZE-1:0]   result_i,
    output logic                                   line_valid,
    input  logic                                   line_ready,
    output logic [511:0]                           line_data,
    output logic                                   finish
);

    localparam int N          = BLOCKS_NUMBER;
    localparam int PTR_W      = (N > 1) ? $clog2(N) : 1;
    localparam int LAUNCH_CNT = (N < TOTAL_STATES) ? N : TOTAL_STATES;
    localparam logic [31:0] TOTAL_W  = 32'(TOTAL_STATES);
    localparam logic [31:0] LAUNCH_W = 32'(LAUNCH_CNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_ISSUE,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;

    logic [31:0]                 r_next_state;
    logic [31:0]                 r_completed;
    logic [N-1:0]                r_active;
    logic [PTR_W-1:0]            r_rr_ptr;
    logic [2:0]                  r_slot;
    logic [511:0]                r_line;

    logic [N-1:0]                r_start;
    logic [N-1:0]                r_retire;
    logic [N*VECTOR_SIZE-1:0]    r_conf;
    logic                        r_line_valid;
    logic                        r_finish;

    logic [N-1:0]                w_cand;
    logic                        w_grant_vld;
    logic [PTR_W-1:0]            w_grant_idx;
    logic [PTR_W-1:0]            w_rr_nxt;
    logic                        w_has_next;
    logic                        w_all_done;
    logic                        w_line_full;
    logic [63:0]                 w_entry;
    logic [VECTOR_SIZE-1:0]      w_issue_conf;

    logic [N-1:0]                w_start_nxt;
    logic [N-1:0]                w_retire_nxt;
    logic [N*VECTOR_SIZE-1:0]    w_conf_nxt;
    logic                        w_line_valid_nxt;
    logic                        w_finish_nxt;

    // Only the low 32 bits of each result are packed into a line.
    logic                        w_unused_result;
    assign w_unused_result = ^result_i;

    assign w_cand      = done_i & r_active;
    assign w_has_next  = (r_next_state < TOTAL_W);
    assign w_all_done  = (r_completed == TOTAL_W);
    assign w_line_full = (r_slot == 3'd0);
    assign w_rr_nxt    = (int'(w_grant_idx) == N - 1) ? '0 : w_grant_idx + PTR_W'(1);
    assign w_entry     = {result_i[int'(w_grant_idx)*VECTOR_SIZE +: 32],
                          transient_i[int'(w_grant_idx)*32 +: 32]};

    // Zero-extended next_state for the worker being restarted.
    always_comb begin
        w_issue_conf       = '0;
        w_issue_conf[31:0] = r_next_state;
    end

    // Round-robin search: first candidate at or above rr_ptr, wrapping modulo N.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] idx_p;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        idx         = 0;
        idx_p       = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_p = PTR_W'(idx);
            if (!w_grant_vld && w_cand[idx_p]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = idx_p;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_LAUNCH;
            S_LAUNCH: w_state_nxt = S_RUN;
            S_RUN:    if (w_grant_vld) w_state_nxt = S_ISSUE;
            S_ISSUE:  w_state_nxt = (w_line_full || w_all_done) ? S_WRITE : S_RUN;
            S_WRITE: begin
                if (line_ready) begin
                    w_state_nxt = w_all_done ? S_FINISH : S_RUN;
                end
            end
            S_FINISH: w_state_nxt = S_FINISH;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        w_start_nxt      = '0;
        w_retire_nxt     = '0;
        w_conf_nxt       = '0;
        w_line_valid_nxt = 1'b0;
        w_finish_nxt     = (w_state_nxt == S_FINISH);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    for (int i = 0; i < N; i++) begin
                        if (i < LAUNCH_CNT) begin
                            w_start_nxt[i] = 1'b1;
                            w_conf_nxt[i*VECTOR_SIZE +: VECTOR_SIZE] = VECTOR_SIZE'(i);
                        end
                    end
                end
            end
            S_RUN: begin
                if (w_grant_vld) begin
                    if (w_has_next) begin
                        w_start_nxt[w_grant_idx] = 1'b1;
                        w_conf_nxt[int'(w_grant_idx)*VECTOR_SIZE +: VECTOR_SIZE] = w_issue_conf;
                    end else begin
                        w_retire_nxt[w_grant_idx] = 1'b1;
                    end
                end
            end
            S_ISSUE: w_line_valid_nxt = (w_state_nxt == S_WRITE);
            S_WRITE: w_line_valid_nxt = !line_ready;
            default: ;
        endcase
    end

    // Registered outputs; pulses last exactly one cycle because the next
    // values default to zero outside the launching/granting transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start      <= '0;
            r_retire     <= '0;
            r_conf       <= '0;
            r_line_valid <= 1'b0;
            r_finish     <= 1'b0;
        end else begin
            r_start      <= w_start_nxt;
            r_retire     <= w_retire_nxt;
            r_conf       <= w_conf_nxt;
            r_line_valid <= w_line_valid_nxt;
            r_finish     <= w_finish_nxt;
        end
    end

    // Bookkeeping: issue counter, completion counter, active set, arbiter
    // pointer and the line buffer being filled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_next_state <= '0;
            r_completed  <= '0;
            r_active     <= '0;
            r_rr_ptr     <= '0;
            r_slot       <= '0;
            r_line       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_active     <= w_start_nxt;
                        r_next_state <= LAUNCH_W;
                        r_completed  <= '0;
                        r_rr_ptr     <= '0;
                        r_slot       <= '0;
                        r_line       <= '0;
                    end
                end
                S_RUN: begin
                    if (w_grant_vld) begin
                        r_line[int'(r_slot)*64 +: 64] <= w_entry;
                        r_slot      <= r_slot + 3'd1;
                        r_completed <= r_completed + 32'd1;
                        r_rr_ptr    <= w_rr_nxt;
                        if (w_has_next) begin
                            r_next_state <= r_next_state + 32'd1;
                        end else begin
                            r_active[w_grant_idx] <= 1'b0;
                        end
                    end
                end
                S_WRITE: begin
                    if (line_ready) begin
                        r_line <= '0;
                        r_slot <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign start_o    = r_start;
    assign retire_o   = r_retire;
    assign conf_o     = r_conf;
    assign line_valid = r_line_valid;
    assign line_data  = r_line;
    assign finish     = r_finish;

endmodule

// File: tb/tb_grn_scheduler.sv
// Bench for grn_scheduler: a 4-worker/10-state instance driven by emulated
// workers, and a 16-worker/5-state instance for the short-run case.
module tb_grn_scheduler;

    localparam int V  = 69;
    localparam int NA = 4;
    localparam int TA = 10;
    localparam int NB = 16;
    localparam int TB = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              start_a, lv_a, lr_a, fin_a;
    logic [NA-1:0]     start_o_a, retire_o_a, done_a;
    logic [NA*V-1:0]   conf_a, result_a;
    logic [NA*32-1:0]  trans_a;
    logic [511:0]      ld_a;

    logic              start_b, lv_b, lr_b, fin_b;
    logic [NB-1:0]     start_o_b, retire_o_b, done_b;
    logic [NB*V-1:0]   conf_b, result_b;
    logic [NB*32-1:0]  trans_b;
    logic [511:0]      ld_b;

    grn_scheduler #(.BLOCKS_NUMBER(NA), .VECTOR_SIZE(V), .TOTAL_STATES(TA)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .start_o(start_o_a), .conf_o(conf_a),
        .retire_o(retire_o_a), .done_i(done_a), .transient_i(trans_a), .result_i(result_a),
        .line_valid(lv_a), .line_ready(lr_a), .line_data(ld_a), .finish(fin_a));

    grn_scheduler #(.BLOCKS_NUMBER(NB), .VECTOR_SIZE(V), .TOTAL_STATES(TB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .start_o(start_o_b), .conf_o(conf_b),
        .retire_o(retire_o_b), .done_i(done_b), .transient_i(trans_b), .result_i(result_b),
        .line_valid(lv_b), .line_ready(lr_b), .line_data(ld_b), .finish(fin_b));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Worker emulation and observation log for instance a.
    bit   auto_mode;
    bit   rand_ready;
    int   w_cnt [NA];
    bit   w_clr [NA];
    bit   w_run [NA];
    int   ev_w[$];
    bit   ev_start[$];
    int   ev_conf[$];
    int   ev_cyc[$];
    logic [511:0] lines[$];
    bit   seen [TA];
    int   hi_bad;

    function automatic logic [31:0] tr_of(input int c);
        return 32'(c * 7 + 100);
    endfunction

    function automatic logic [31:0] res_of(input int c);
        return 32'hC0DE_0000 ^ 32'(c);
    endfunction

    // Decodes a written line: the first n_exp entries must each carry a
    // not-yet-seen state with matching transient/result, the rest must be 0.
    function automatic int line_bad(input logic [511:0] ln, input int n_exp);
        int bad;
        int t;
        logic [63:0] e;
        bad = 0;
        for (int j = 0; j < 8; j++) begin
            e = ln[64*j +: 64];
            if (j < n_exp) begin
                t = int'(e[31:0]) - 100;
                if (t < 0 || (t % 7) != 0 || (t / 7) >= TA) bad++;
                else if (e[63:32] != res_of(t / 7) || seen[t / 7]) bad++;
                else seen[t / 7] = 1'b1;
            end else if (e != 64'd0) begin
                bad++;
            end
        end
        return bad;
    endfunction

    task automatic model_reset();
        done_a = '0;
        for (int i = 0; i < NA; i++) begin
            w_cnt[i] = 0; w_clr[i] = 0; w_run[i] = 0;
            trans_a[i*32 +: 32] = tr_of(i);
            result_a[i*V +: V]  = {{(V-32){1'b1}}, res_of(i)};
        end
        ev_w.delete(); ev_start.delete(); ev_conf.delete(); ev_cyc.delete();
        lines.delete();
        for (int c = 0; c < TA; c++) seen[c] = 1'b0;
        hi_bad = 0;
    endtask

    // One clock of instance a: records a handshake, advances the workers,
    // logs pulses, and picks the next line_ready.
    task automatic step();
        logic hs;
        logic [511:0] snap;
        int c;
        hs = lv_a && lr_a;
        snap = ld_a;
        @(posedge clk); #1;
        cyc++;
        if (hs) lines.push_back(snap);
        if (auto_mode) begin
            for (int i = 0; i < NA; i++) begin
                if (w_clr[i]) begin
                    done_a[i] = 1'b0; w_clr[i] = 1'b0;
                end else if (w_run[i] && w_cnt[i] > 0) begin
                    w_cnt[i]--;
                    if (w_cnt[i] == 0) done_a[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NA; i++) begin
            if (start_o_a[i]) begin
                c = int'(conf_a[i*V +: 32]);
                if (conf_a[i*V+32 +: V-32] != '0) hi_bad++;
                ev_w.push_back(i); ev_start.push_back(1'b1); ev_conf.push_back(c); ev_cyc.push_back(cyc);
                w_run[i] = 1'b1; w_clr[i] = 1'b1; w_cnt[i] = int'($urandom_range(1, 8));
                trans_a[i*32 +: 32] = tr_of(c);
                result_a[i*V +: V]  = {{(V-32){1'b1}}, res_of(c)};
            end
            if (retire_o_a[i]) begin
                ev_w.push_back(i); ev_start.push_back(1'b0); ev_conf.push_back(-1); ev_cyc.push_back(cyc);
                w_run[i] = 1'b0; w_clr[i] = 1'b1;
            end
        end
        if (rand_ready) lr_a = ($urandom_range(0, 3) != 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++; if (start_o_a !== '0 || retire_o_a !== '0) begin errors++; $display("FAIL reset_pulses_a: got %h/%h required 0/0", start_o_a, retire_o_a); end
        checks++; if (conf_a !== '0) begin errors++; $display("FAIL reset_conf_a: got %h required 0", conf_a); end
        checks++; if (lv_a !== 1'b0 || fin_a !== 1'b0) begin errors++; $display("FAIL reset_flags_a: got lv=%b fin=%b required 0 0", lv_a, fin_a); end
        checks++; if (ld_a !== '0) begin errors++; $display("FAIL reset_line_a: got %h required 0", ld_a); end
        checks++; if (start_o_b !== '0 || retire_o_b !== '0 || lv_b !== 1'b0 || fin_b !== 1'b0 || conf_b !== '0 || ld_b !== '0) begin
            errors++; $display("FAIL reset_b: got start=%h retire=%h lv=%b fin=%b required all 0", start_o_b, retire_o_b, lv_b, fin_b);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_round_robin_backpressure();
        int exp_w [8] = '{1, 3, 1, 3, 1, 3, 1, 3};
        int exp_c [8] = '{4, 5, 6, 7, 8, 9, -1, -1};
        int bad;
        int k;
        logic [511:0] snap;
        auto_mode = 0; rand_ready = 0; lr_a = 1'b0;
        model_reset();
        start_a = 1'b1; step(); start_a = 1'b0;
        checks++; if (start_o_a !== 4'hF) begin errors++; $display("FAIL launch_mask: got %h required f", start_o_a); end
        bad = 0;
        for (int i = 0; i < NA; i++) if (i >= ev_conf.size() || ev_conf[i] != i || ev_w[i] != i) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL launch_conf: got %0d bad slices required 0", bad); end
        ev_w.delete(); ev_start.delete(); ev_conf.delete(); ev_cyc.delete();
        done_a[1] = 1'b1; done_a[3] = 1'b1;
        for (k = 0; k < 100 && lv_a !== 1'b1; k++) step();
        checks++; if (lv_a !== 1'b1) begin errors++; $display("FAIL rr_line_timeout: got lv=%b required 1", lv_a); end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (i >= ev_w.size()) bad++;
            else if (ev_w[i] != exp_w[i] || ev_start[i] != (exp_c[i] >= 0) || ev_conf[i] != exp_c[i]) bad++;
        end
        checks++; if (bad != 0 || ev_w.size() != 8) begin errors++; $display("FAIL rr_order: got %0d bad of %0d events required 0 of 8", bad, ev_w.size()); end
        bad = 0;
        for (int i = 1; i < ev_cyc.size(); i++) if (ev_cyc[i] - ev_cyc[i-1] != 2) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rr_spacing: got %0d gaps not equal 2 required 0", bad); end
        done_a[0] = 1'b1;
        snap = ld_a;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (lv_a !== 1'b1 || ld_a !== snap || start_o_a !== '0 || retire_o_a !== '0) bad++;
        end
        checks++; if (bad != 0 || ev_w.size() != 8) begin errors++; $display("FAIL backpressure_hold: got %0d bad cycles, %0d events required 0, 8", bad, ev_w.size()); end
        lr_a = 1'b1;
        step();
        checks++; if (lines.size() != 1 || lv_a !== 1'b0) begin errors++; $display("FAIL bp_handshake: got %0d lines lv=%b required 1 0", lines.size(), lv_a); end
        step();
        checks++; if (retire_o_a !== 4'b0001) begin errors++; $display("FAIL pending_after_write: got %h required 1", retire_o_a); end
        done_a[2] = 1'b1;
        for (k = 0; k < 50 && fin_a !== 1'b1; k++) step();
        checks++; if (fin_a !== 1'b1) begin errors++; $display("FAIL rr_finish: got %b required 1", fin_a); end
        checks++; if (ev_w.size() != 10 || ev_w[9] != 2 || ev_start[9] != 1'b0) begin errors++; $display("FAIL rr_tail: got %0d events required 10 ending in retire 2", ev_w.size()); end
        bad = 0;
        if (lines.size() == 2) bad = line_bad(lines[0], 8) + line_bad(lines[1], 2); else bad = 99;
        for (int c = 0; c < TA; c++) if (!seen[c]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rr_lines: got %0d bad entries over %0d lines required 0 over 2", bad, lines.size()); end
        start_a = 1'b1; step(); start_a = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++; if (fin_a !== 1'b1 || start_o_a !== '0 || retire_o_a !== '0 || lv_a !== 1'b0 || conf_a !== '0 || ld_a !== '0 || ev_w.size() != 10) begin
            errors++; $display("FAIL finish_sticky: got fin=%b start=%h events=%0d required 1 0 10", fin_a, start_o_a, ev_w.size());
        end
    endtask

    task automatic test_reset_mid();
        int k;
        int bad;
        rst = 1'b1; step(); rst = 1'b0;
        auto_mode = 1; rand_ready = 0; lr_a = 1'b0;
        model_reset();
        start_a = 1'b1; step(); start_a = 1'b0;
        for (k = 0; k < 300 && lv_a !== 1'b1; k++) step();
        checks++; if (lv_a !== 1'b1) begin errors++; $display("FAIL mid_write_timeout: got lv=%b required 1", lv_a); end
        rst = 1'b1; step();
        checks++; if (start_o_a !== '0 || retire_o_a !== '0 || conf_a !== '0 || lv_a !== 1'b0 || ld_a !== '0 || fin_a !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outputs: got start=%h retire=%h lv=%b fin=%b required all 0", start_o_a, retire_o_a, lv_a, fin_a);
        end
        rst = 1'b0;
        model_reset();
        step();
        start_a = 1'b1; step(); start_a = 1'b0;
        bad = 0;
        for (int i = 0; i < NA; i++) if (i >= ev_conf.size() || ev_conf[i] != i) bad++;
        checks++; if (bad != 0 || start_o_a !== 4'hF) begin errors++; $display("FAIL rerun_from_zero: got %0d bad confs start=%h required 0 f", bad, start_o_a); end
    endtask

    task automatic test_random_run(input int iter);
        int k, bad, n_start, n_ret, min_gap;
        logic [NA-1:0] ret_mask;
        rst = 1'b1; step(); rst = 1'b0;
        auto_mode = 1; rand_ready = 1; lr_a = 1'b1;
        model_reset();
        start_a = 1'b1; step(); start_a = 1'b0;
        for (k = 0; k < 3000 && fin_a !== 1'b1; k++) step();
        checks++; if (fin_a !== 1'b1) begin errors++; $display("FAIL rand%0d_finish: got %b required 1", iter, fin_a); end
        n_start = 0; n_ret = 0; bad = 0; ret_mask = '0; min_gap = 1000;
        for (int i = 0; i < ev_w.size(); i++) begin
            if (ev_start[i]) begin
                if (ev_conf[i] != n_start) bad++;
                n_start++;
            end else begin
                if (ret_mask[ev_w[i]]) bad++;
                ret_mask[ev_w[i]] = 1'b1;
                n_ret++;
            end
            if (i >= NA && ev_cyc[i] - ev_cyc[i-1] < min_gap) min_gap = ev_cyc[i] - ev_cyc[i-1];
        end
        checks++; if (n_start != TA || bad != 0 || hi_bad != 0) begin errors++; $display("FAIL rand%0d_issue: got %0d starts %0d bad required %0d 0", iter, n_start, bad + hi_bad, TA); end
        checks++; if (n_ret != NA || ret_mask !== 4'hF) begin errors++; $display("FAIL rand%0d_retire: got %0d mask %h required %0d f", iter, n_ret, ret_mask, NA); end
        checks++; if (min_gap < 2) begin errors++; $display("FAIL rand%0d_rate: got gap %0d required >=2", iter, min_gap); end
        bad = 0;
        if (lines.size() == 2) bad = line_bad(lines[0], 8) + line_bad(lines[1], 2); else bad = 99;
        for (int c = 0; c < TA; c++) if (!seen[c]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rand%0d_lines: got %0d bad over %0d lines required 0 over 2", iter, bad, lines.size()); end
        checks++; if (start_o_a !== '0 || retire_o_a !== '0 || lv_a !== 1'b0 || ld_a !== '0) begin errors++; $display("FAIL rand%0d_finish_quiet: got start=%h lv=%b required 0 0", iter, start_o_a, lv_a); end
    endtask

    task automatic test_total_below_n();
        int ret_q[$];
        int n_starts, bad, k;
        logic hs;
        logic [511:0] snap;
        logic [511:0] lines_b[$];
        logic [63:0] exp_e;
        lr_b = 1'b1; done_b = '0; done_b[7] = 1'b1;
        for (int i = 0; i < NB; i++) begin
            trans_b[i*32 +: 32] = tr_of(i);
            result_b[i*V +: V]  = {{(V-32){1'b1}}, res_of(i)};
        end
        start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
        checks++; if (start_o_b !== 16'h001F || retire_o_b !== '0) begin errors++; $display("FAIL small_launch: got %h/%h required 001f/0", start_o_b, retire_o_b); end
        bad = 0;
        for (int i = 0; i < NB; i++) if (conf_b[i*V +: V] !== ((i < TB) ? V'(i) : V'(0))) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL small_conf: got %0d bad slices required 0", bad); end
        done_b[4:0] = 5'h1F;
        n_starts = 0;
        for (k = 0; k < 200 && fin_b !== 1'b1; k++) begin
            hs = lv_b && lr_b; snap = ld_b;
            @(posedge clk); #1;
            if (hs) lines_b.push_back(snap);
            for (int i = 0; i < NB; i++) if (retire_o_b[i]) ret_q.push_back(i);
            if (start_o_b !== '0) n_starts++;
        end
        checks++; if (fin_b !== 1'b1) begin errors++; $display("FAIL small_finish: got %b required 1", fin_b); end
        bad = 0;
        for (int i = 0; i < TB; i++) if (i >= ret_q.size() || ret_q[i] != i) bad++;
        checks++; if (bad != 0 || ret_q.size() != TB || n_starts != 0) begin errors++; $display("FAIL small_retire: got %0d retires %0d starts required %0d 0", ret_q.size(), n_starts, TB); end
        bad = 0;
        if (lines_b.size() != 1) bad = 99;
        else for (int j = 0; j < 8; j++) begin
            exp_e = (j < TB) ? {res_of(j), tr_of(j)} : 64'd0;
            if (lines_b[0][64*j +: 64] !== exp_e) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL small_line: got %0d bad entries over %0d lines required 0 over 1", bad, lines_b.size()); end
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; lr_a = 1'b0; done_a = '0; trans_a = '0; result_a = '0;
        start_b = 1'b0; lr_b = 1'b0; done_b = '0; trans_b = '0; result_b = '0;
        auto_mode = 0; rand_ready = 0;
        model_reset();
        test_reset();
        test_round_robin_backpressure();
        test_reset_mid();
        for (int it = 0; it < 4; it++) test_random_run(it);
        test_total_below_n();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/grn_scheduler.md
# grn_scheduler

Dispatches GRN initial states to a bank of `BLOCKS_NUMBER` GRN worker blocks and services their completions with a fair round-robin arbiter. It hands each freed worker the next state or retires it. Results are packed into 512-bit lines and handed to the write channel with a valid/ready handshake. It sits between the worker array and the host write path, and replaces fixed-priority done handling with deterministic, starvation-free sequencing.

## Interface
Parameters:
- `BLOCKS_NUMBER`, 16: number of workers N (2..32).
- `VECTOR_SIZE`, 69: width of one configuration vector.
- `TOTAL_STATES`, 96: initial states to simulate (1..2^31-1).

Ports (reset `rst` synchronous, active-high; clock `clk`):
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous active-high reset.
- `start`, in, 1: one-cycle run request. Sampled only in IDLE.
- `start_o`, out, N: per-worker start pulse.
- `conf_o`, out, N*VECTOR_SIZE: per-worker initial state. Slice i is `[i*VECTOR_SIZE +: VECTOR_SIZE]`.
- `retire_o`, out, N: per-worker retire pulse. The worker stops.
- `done_i`, in, N: per-worker completion level. It is held until that worker sees a start or retire pulse.
- `transient_i`, in, N*32: per-worker transient length, slice `[i*32 +: 32]`.
- `result_i`, in, N*VECTOR_SIZE: per-worker final configuration.
- `line_valid`, out, 1: `line_data` holds a packed line.
- `line_ready`, in, 1: the consumer accepts the line.
- `line_data`, out, 512: eight 64-bit entries.
- `finish`, out, 1: all states are complete and written. Sticky until `rst`.

## Operation
- **State registers:**
  - `next_state` (32b): next state to issue.
  - `completed` (32b): results captured.
  - `active` (N b): workers currently running.
  - `rr_ptr` (log2 N b): round-robin start index.
  - `slot` (3b): next free entry in the line buffer.
- **States:** IDLE, LAUNCH, RUN, ISSUE, WRITE, FINISH.
- **IDLE.** All outputs are 0. When `start`=1, go to LAUNCH.
- **LAUNCH** (1 cycle):
  - Let L = min(N, TOTAL_STATES).
  - For i<L: `start_o[i]`=1, `conf_o` slice i = i (zero-extended), `active[i]`=1.
  - Set `next_state`=L, then go to RUN.
- **RUN.**
  - Candidates are `done_i & active`.
  - Grant the first candidate searching from index `rr_ptr` upward, wrapping modulo N.
  - If there is no candidate, stay in RUN.
  - On a grant g:
    - Capture the entry into buffer entry `slot`. Bits `[64*slot +: 32]` = `transient_i` slice g. Bits `[64*slot+32 +: 32]` = `result_i` slice g bits [31:0].
    - Update counters: `slot`++, `completed`++, `rr_ptr` = (g+1) mod N.
    - If `next_state` < TOTAL_STATES: register `start_o[g]`=1, `conf_o` slice g = `next_state`, then `next_state`++.
    - Otherwise: register `retire_o[g]`=1 and clear `active[g]`.
    - Go to ISSUE.
- **ISSUE** (1 cycle):
  - The pulses are visible this cycle and are cleared at its end.
  - If `slot` wrapped to 0 (line full), or `completed`==TOTAL_STATES: go to WRITE and set `line_valid`=1.
  - Otherwise go to RUN.
- **WRITE.**
  - `line_valid` is held at 1, and `line_data` is stable until `line_ready`=1.
  - On handshake: clear the buffer to 0, set `slot`=0, drop `line_valid`.
  - Then go to FINISH if `completed`==TOTAL_STATES, else to RUN.
  - No grants occur while in WRITE.
- **Partial last line.** Entries at `slot` and above are 0. Total lines written = ceil(TOTAL_STATES/8).
- **FINISH.** `finish`=1 and all other outputs are 0. Leave only by `rst`; `start` is ignored.
- **Worker contract.** A worker deasserts `done_i` in the cycle after its start or retire pulse. `done_i` from inactive workers is ignored.
- **Reset.**
  - All registers and outputs clear at the next edge: `start_o`, `retire_o`, `conf_o`, `line_valid`, `line_data` and `finish` = 0, `rr_ptr`=0, state=IDLE.
  - Reset during WRITE drops `line_valid` without a handshake; that line is lost.

## Timing
- **Start to LAUNCH.** `start` sampled high at edge t gives `start_o` for LAUNCH workers high during cycle t+1, for one cycle.
- **Grant.** `done_i[g]` sampled in RUN at edge t gives the `start_o[g]`/`retire_o[g]` pulse in cycle t+1 (ISSUE).
- **Line output.** If the line completes, `line_valid` is high from cycle t+2.
- **Throughput.** At most one grant per 2 cycles. With no backpressure, max rate is 1 result per 2 cycles.
- **Handshake.** The transfer occurs on an edge with `line_valid`&&`line_ready`. The earliest next grant is the following cycle.
- **Simultaneous completions.** Served in round-robin order. The losers keep `done_i` high and are granted in later RUN cycles.

## Test plan
- **Basic run.** N=4, TOTAL=10, each worker's done 3 cycles after start, `line_ready`=1 → `conf_o` values 0..9 each issued once, and exactly 4 retire pulses. Two lines result: 8 entries, then 2 entries with bits [511:128]=0. `finish`=1 after the second handshake.
- **Round-robin order.** `rr_ptr`=0; `done_i` 1 and 3 rise in the same cycle → grant 1, then 3 two cycles later, leaving `rr_ptr`=0. With 1 and 3 held continuously, they alternate; neither starves.
- **Backpressure.** A full line with `line_ready`=0 for 5 cycles → `line_data` stable and `line_valid`=1 throughout. No start or retire pulses; pending `done_i` is served after the handshake.
- **TOTAL below N.** N=16, TOTAL=5 → LAUNCH pulses only `start_o[4:0]`. Five completions give 5 retires, one line whose entries 5..7 are 0, then `finish`.
- **Reset mid-operation.** `rst` asserted in WRITE → next cycle all outputs are 0 and state is IDLE. A new `start` reruns from `conf_o`=0.
- **Inactive done ignored.** Force `done_i[7]` high while worker 7 is retired → no grant and no entry captured.
